zion_rvi_slt_share_arb: RTL and testbench
=========================================

// Module: zion_rvi_slt_share_arb
// PURPOSE
//  Shares one RVI set-less-than compare datapath between REQ_NUM requesters, e.g. ALU SLT/SLTU
//  issue and branch-compare precompute. Round-robin arbitration with valid/ready handshakes.
//  One registered output stage returns the 0/1 result and the winning requester ID.
//  Sits in EX, between the issue ports and the writeback/branch units.
// PARAMETERS
//  RV64       0                 1 = 64-bit datapath, 0 = 32-bit
//  CPU_WIDTH  32*(RV64+1)       operand/result width
//  REQ_NUM    2                 number of requesters, >=2
//  ID_W       $clog2(REQ_NUM)   localparam, response ID width
// PORTS
//  clk             in   1                  clock, all state on rising edge
//  rst_n           in   1                  asynchronous reset, active-low
//  req_vld_i       in   REQ_NUM            per-requester request valid
//  req_s1_i        in   REQ_NUM*CPU_WIDTH  operand s1, one slice per requester
//  req_s2_i        in   REQ_NUM*CPU_WIDTH  operand s2, one slice per requester
//  req_unsigned_i  in   REQ_NUM            1 = SLTU compare, 0 = signed SLT
//  req_rdy_o       out  REQ_NUM            one-hot grant; request accepted when vld&rdy
//  rsp_vld_o       out  1                  result valid
//  rsp_id_o        out  ID_W               index of the requester owning the result
//  rsp_rslt_o      out  CPU_WIDTH          {CPU_WIDTH-1 zeros, lt}
//  rsp_rdy_i       in   1                  consumer ready
//  busy_o          out  1                  = rsp_vld_o | (|req_vld_i)
// BEHAVIOUR
//  - Reset (async on rst_n fall): rsp_vld_o=0, rsp_id_o=0, rsp_rslt_o=0, rr pointer=0.
//    Reset mid-transaction discards the pending result.
//  - can_acc = ~rsp_vld_o | rsp_rdy_i.
//  - req_rdy_o is combinational: the one-hot RR winner among req_vld_i, gated by can_acc.
//    It is zero when no request is valid.
//  - Round robin: search starts at pointer ptr, ascending with wrap REQ_NUM-1 -> 0.
//    - On an accept by index g, ptr <= (g==REQ_NUM-1) ? 0 : g+1.
//    - With no accept, ptr holds.
//    - Any continuously-valid requester is granted within REQ_NUM accepts.
//  - Compare: lt = {~u & s1[MSB], s1} < {~u & s2[MSB], s2}, as a signed compare on
//    CPU_WIDTH+1 bits. Equal operands give lt=0. There is no W (32-bit-on-RV64) variant.
//  - Latency: an accept in cycle N gives rsp_vld_o=1 in N+1, with rsp_id_o=g and
//    rsp_rslt_o={0,lt}.
//  - Backpressure: while rsp_vld_o & ~rsp_rdy_i, rsp_* hold stable and req_rdy_o=0.
//  - Drain + accept in the same cycle is allowed, so throughput is 1/cycle.
//  - Drain with no accept: rsp_vld_o<=0. rsp_id_o/rsp_rslt_o hold their last value
//    (don't-care when not valid).
//  - Requesters hold vld and operands stable until accepted. Dropping vld before accept
//    is legal, and that requester is simply not granted.
//  - Only the granted requester's operands are sampled; other slices are ignored.
// STRUCTURE
//  - Package zion_rvi_slt_arb_pkg holds:
//    - the RR pointer-advance function;
//    - the width-agnostic slt compare function (s1, s2, unsignedFlg) -> lt, shared with the
//      core SLT unit.
//  - Sub-module zion_rr_arb #(REQ_NUM): inputs vld, ptr, en -> one-hot gnt and index.
//    Pointer state lives in the parent.
//  - Parent holds the operand mux, the compare, and the output register stage.
// TESTING (CPU_WIDTH=32 unless noted)
//  1. req0 s1=0xFFFF_FFFF, s2=1, u=0 -> next cycle rsp_vld=1, id=0, rslt=1.
//     Repeat with u=1 -> rslt=0.
//  2. s1=0x7FFF_FFFF, s2=0x8000_0000: u=0 -> rslt=0, u=1 -> rslt=1.
//     s1=s2=0x8000_0000 -> rslt=0.
//  3. REQ_NUM=3, all vld held, rsp_rdy=1 -> grants 0,1,2,0,1,... with one rsp per cycle
//     and IDs matching.
//  4. rsp_vld=1, rsp_rdy=0 for 3 cycles -> req_rdy=0 and rsp_* stable.
//     Raising rsp_rdy drains and accepts the next request in the same cycle.
//  5. Async rst_n pulse while rsp_vld=1 and the pointer is nonzero -> all outputs 0
//     immediately; the first grant after release goes to req0.
//  6. RV64=1: s1=0x8000_0000_0000_0000, s2=0, u=0 -> rslt=1; u=1 -> rslt=0, upper 63 bits 0.

Source files
------------

// File: rtl/zion_rvi_slt_arb_pkg.sv
// Shared helpers for the RVI set-less-than arbiter.
//   rr_next : round-robin pointer advance (wraps REQ_NUM-1 -> 0)
//   slt_lt  : width-agnostic SLT/SLTU compare, shared with the core SLT unit.
//             Operands are passed in a XLEN_MAX-wide container; only the low
//             'width' bits are significant.
package zion_rvi_slt_arb_pkg;

    localparam int XLEN_MAX = 64;

    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

    // Extend both operands by one bit (sign bit for SLT, zero for SLTU)
    // and do a single signed compare on width+1 bits.
    function automatic logic slt_lt(input logic [XLEN_MAX-1:0] s1,
                                    input logic [XLEN_MAX-1:0] s2,
                                    input logic                unsigned_flg,
                                    input int                  width);
        logic [XLEN_MAX:0] a;
        logic [XLEN_MAX:0] b;
        logic              e1;
        logic              e2;
        e1 = ~unsigned_flg & s1[width-1];
        e2 = ~unsigned_flg & s2[width-1];
        for (int i = 0; i < XLEN_MAX; i++) begin
            a[i] = (i < width) ? s1[i] : e1;
            b[i] = (i < width) ? s2[i] : e2;
        end
        a[XLEN_MAX] = e1;
        b[XLEN_MAX] = e2;
        return $signed(a) < $signed(b);
    endfunction

endpackage

// File: rtl/zion_rr_arb.sv
// Combinational round-robin picker. Pointer state is held by the parent.
//   vld_i : per-requester valid
//   ptr_i : search start index
//   en_i  : grant enable (downstream can accept)
//   gnt_o : one-hot grant, zero when disabled or nothing valid
//   idx_o : index of the winner (valid whenever any vld_i is set)
//   acc_o : a grant is issued this cycle
module zion_rr_arb #(
    parameter int REQ_NUM = 2,
    localparam int ID_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic [REQ_NUM-1:0] vld_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [REQ_NUM-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               acc_o
);

    logic found;
    int   cand;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        cand  = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= REQ_NUM) cand = cand - REQ_NUM;
            if (!found && vld_i[cand]) begin
                found = 1'b1;
                idx_o = ID_W'(cand);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        acc_o = found & en_i;
        if (acc_o) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/zion_rvi_slt_share_arb.sv
// Shared RVI SLT/SLTU compare datapath with round-robin arbitration between
// REQ_NUM requesters and one registered response stage.
//   req_vld_i/req_s1_i/req_s2_i/req_unsigned_i : per-requester request
//   req_rdy_o                                 : one-hot grant (accept = vld & rdy)
//   rsp_vld_o/rsp_id_o/rsp_rslt_o/rsp_rdy_i   : response handshake, rslt = {0, lt}
//   busy_o                                    : response pending or any request valid
module zion_rvi_slt_share_arb
    import zion_rvi_slt_arb_pkg::*;
#(
    parameter int RV64      = 0,
    parameter int CPU_WIDTH = 32 * (RV64 + 1),
    parameter int REQ_NUM   = 2,
    localparam int ID_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REQ_NUM-1:0]           req_vld_i,
    input  logic [REQ_NUM*CPU_WIDTH-1:0] req_s1_i,
    input  logic [REQ_NUM*CPU_WIDTH-1:0] req_s2_i,
    input  logic [REQ_NUM-1:0]           req_unsigned_i,
    output logic [REQ_NUM-1:0]           req_rdy_o,
    output logic                         rsp_vld_o,
    output logic [ID_W-1:0]              rsp_id_o,
    output logic [CPU_WIDTH-1:0]         rsp_rslt_o,
    input  logic                         rsp_rdy_i,
    output logic                         busy_o
);

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic                rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_lt_q, rsp_lt_d;

    logic                can_acc;
    logic                acc;
    logic [ID_W-1:0]     gnt_idx;
    logic [XLEN_MAX-1:0] s1_ext, s2_ext;
    logic                u_sel;
    logic                lt;

    // Drain and accept may coincide, giving one result per cycle.
    assign can_acc = ~rsp_vld_q | rsp_rdy_i;

    zion_rr_arb #(.REQ_NUM(REQ_NUM)) u_arb (
        .vld_i (req_vld_i),
        .ptr_i (ptr_q),
        .en_i  (can_acc),
        .gnt_o (req_rdy_o),
        .idx_o (gnt_idx),
        .acc_o (acc)
    );

    // Only the winner's operand slice reaches the comparator.
    always_comb begin
        s1_ext = '0;
        s2_ext = '0;
        s1_ext[CPU_WIDTH-1:0] = req_s1_i[int'(gnt_idx)*CPU_WIDTH +: CPU_WIDTH];
        s2_ext[CPU_WIDTH-1:0] = req_s2_i[int'(gnt_idx)*CPU_WIDTH +: CPU_WIDTH];
        u_sel  = req_unsigned_i[gnt_idx];
        lt     = slt_lt(s1_ext, s2_ext, u_sel, CPU_WIDTH);
    end

    always_comb begin
        ptr_d     = ptr_q;
        rsp_vld_d = rsp_vld_q;
        rsp_id_d  = rsp_id_q;
        rsp_lt_d  = rsp_lt_q;
        if (acc) begin
            ptr_d     = ID_W'(rr_next(int'(gnt_idx), REQ_NUM));
            rsp_vld_d = 1'b1;
            rsp_id_d  = gnt_idx;
            rsp_lt_d  = lt;
        end else if (rsp_rdy_i) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_lt_q  <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_lt_q  <= rsp_lt_d;
        end
    end

    assign rsp_vld_o  = rsp_vld_q;
    assign rsp_id_o   = rsp_id_q;
    assign rsp_rslt_o = {{(CPU_WIDTH-1){1'b0}}, rsp_lt_q};
    assign busy_o     = rsp_vld_q | (|req_vld_i);

endmodule

// File: tb/tb_zion_rvi_slt_share_arb.sv
module tb_zion_rvi_slt_share_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- 32-bit, 3 requesters ----------------
    logic [2:0]  vld32 = '0;
    logic [95:0] s1_32 = '0;
    logic [95:0] s2_32 = '0;
    logic [2:0]  uns32 = '0;
    logic [2:0]  rdy32;
    logic        rvld32;
    logic [1:0]  rid32;
    logic [31:0] rslt32;
    logic        rrdy32 = 1'b1;
    logic        busy32;

    zion_rvi_slt_share_arb #(.RV64(0), .REQ_NUM(3)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_vld_i(vld32), .req_s1_i(s1_32), .req_s2_i(s2_32), .req_unsigned_i(uns32),
        .req_rdy_o(rdy32),
        .rsp_vld_o(rvld32), .rsp_id_o(rid32), .rsp_rslt_o(rslt32), .rsp_rdy_i(rrdy32),
        .busy_o(busy32)
    );

    // ---------------- 64-bit, 2 requesters ----------------
    logic [1:0]   vld64 = '0;
    logic [127:0] s1_64 = '0;
    logic [127:0] s2_64 = '0;
    logic [1:0]   uns64 = '0;
    logic [1:0]   rdy64;
    logic         rvld64;
    logic [0:0]   rid64;
    logic [63:0]  rslt64;
    logic         rrdy64 = 1'b1;
    logic         busy64;

    zion_rvi_slt_share_arb #(.RV64(1), .REQ_NUM(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_vld_i(vld64), .req_s1_i(s1_64), .req_s2_i(s2_64), .req_unsigned_i(uns64),
        .req_rdy_o(rdy64),
        .rsp_vld_o(rvld64), .rsp_id_o(rid64), .rsp_rslt_o(rslt64), .rsp_rdy_i(rrdy64),
        .busy_o(busy64)
    );

    // ---------------- reference model + scoreboard (32-bit DUT) ----------------
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] rslt;
    } exp_t;

    exp_t sb[$];
    int   m_ptr = 0;
    logic m_vld = 1'b0;
    logic mon_en = 1'b0;

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (u) return a < b;
        return $signed(a) < $signed(b);
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            exp_t        e;
            logic [2:0]  g;
            int          w;
            logic        can;
            check("rsp_vld", rvld32, m_vld);
            check("busy", busy32, m_vld | (|vld32));
            if (rvld32 && rrdy32) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_id", rid32, e.id);
                    check("rsp_rslt", rslt32, e.rslt);
                end
            end
            can = ~m_vld | rrdy32;
            g = '0;
            w = -1;
            for (int i = 0; i < 3; i++) begin
                int c;
                c = (m_ptr + i) % 3;
                if (w < 0 && vld32[c]) w = c;
            end
            if (can && w >= 0) g[w] = 1'b1;
            check("req_rdy", rdy32, g);
            if (can && w >= 0) begin
                e.id   = 2'(w);
                e.rslt = {31'b0, ref_lt(s1_32[w*32 +: 32], s2_32[w*32 +: 32], uns32[w])};
                sb.push_back(e);
                m_ptr = (w + 1) % 3;
                m_vld = 1'b1;
            end else if (rrdy32) begin
                m_vld = 1'b0;
            end
        end
    end

    task automatic send(input int r, input logic [31:0] a, input logic [31:0] b, input logic u);
        bit done;
        done = 0;
        @(posedge clk); #1;
        vld32[r] = 1'b1;
        s1_32[r*32 +: 32] = a;
        s2_32[r*32 +: 32] = b;
        uns32[r] = u;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (rdy32[r]) begin
                @(posedge clk); #1;
                vld32[r] = 1'b0;
                done = 1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    logic [1:0]  cap_id;
    logic [31:0] cap_rslt;
    logic [2:0]  gl;

    initial begin
        #12;
        check("rst_rsp_vld", rvld32, 0);
        check("rst_rsp_id", rid32, 0);
        check("rst_rsp_rslt", rslt32, 0);
        check("rst_rdy", rdy32, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Signed/unsigned corner cases on requester 0.
        send(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        send(0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        send(0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        send(0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        send(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        send(1, 32'h5, 32'h5, 1'b1);
        send(2, 32'h0, 32'hFFFF_FFFF, 1'b0);
        repeat (2) @(posedge clk);

        // All three requesters continuously valid: round-robin at full rate.
        #1;
        for (int r = 0; r < 3; r++) begin
            s1_32[r*32 +: 32] = $urandom;
            s2_32[r*32 +: 32] = $urandom;
            uns32[r] = 1'($urandom_range(0, 1));
        end
        vld32 = 3'b111;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            gl = rdy32;
            @(posedge clk); #1;
            for (int r = 0; r < 3; r++) if (gl[r]) begin
                s1_32[r*32 +: 32] = (k % 2 == 0) ? 32'h8000_0000 | $urandom : $urandom;
                s2_32[r*32 +: 32] = $urandom;
                uns32[r] = 1'($urandom_range(0, 1));
            end
        end

        // Backpressure for three cycles, then drain + accept together.
        rrdy32 = 1'b0;
        @(negedge clk);
        cap_id = rid32;
        cap_rslt = rslt32;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_rdy", rdy32, 0);
            check("bp_vld", rvld32, 1);
            check("bp_id_stable", rid32, cap_id);
            check("bp_rslt_stable", rslt32, cap_rslt);
        end
        @(posedge clk); #1;
        rrdy32 = 1'b1;
        @(negedge clk);
        check("drain_accept_onehot", $countones(rdy32), 1);
        @(posedge clk); #1;
        vld32 = '0;
        repeat (3) @(posedge clk);

        // Async reset with a held result and nonzero pointer.
        rrdy32 = 1'b0;
        send(0, 32'h1, 32'h2, 1'b0);
        @(negedge clk);
        check("pre_rst_vld", rvld32, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_vld", rvld32, 0);
        check("arst_rsp_id", rid32, 0);
        check("arst_rsp_rslt", rslt32, 0);
        check("arst_busy", busy32, 0);
        sb.delete();
        m_ptr = 0;
        m_vld = 1'b0;
        rrdy32 = 1'b1;
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vld32 = 3'b110;
        s1_32 = {32'h3, 32'h3, 32'h0};
        vld32 = 3'b111;
        @(negedge clk);
        check("post_rst_gnt", rdy32, 3'b001);
        @(posedge clk); #1;
        vld32 = '0;
        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);

        // 64-bit datapath.
        mon_en = 1'b0;
        @(posedge clk); #1;
        vld64 = 2'b01;
        s1_64[63:0] = 64'h8000_0000_0000_0000;
        s2_64[63:0] = 64'h0;
        uns64[0] = 1'b0;
        @(negedge clk);
        check("rv64_gnt", rdy64, 2'b01);
        @(posedge clk); #1;
        uns64[0] = 1'b1;
        @(negedge clk);
        check("rv64_s_vld", rvld64, 1);
        check("rv64_s_id", rid64, 0);
        check("rv64_s_rslt", rslt64, 64'h1);
        check("rv64_gnt2", rdy64, 2'b01);
        @(posedge clk); #1;
        vld64 = 2'b11;
        s1_64[127:64] = 64'hFFFF_FFFF_FFFF_FFFE;
        s2_64[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
        uns64[1] = 1'b1;
        @(negedge clk);
        check("rv64_u_rslt", rslt64, 64'h0);
        check("rv64_rr_gnt", rdy64, 2'b10);
        @(posedge clk); #1;
        vld64 = '0;
        @(negedge clk);
        check("rv64_id1", rid64, 1);
        check("rv64_u_rslt2", rslt64, 64'h1);
        @(negedge clk);
        check("rv64_idle_vld", rvld64, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
